// File: rtl/prodacc_pkg.sv
// Shared types and constants for the product accumulator.
// Saturating arithmetic is selected by the PRODUCT_ACCUMULATOR_SATURATE_EN macro.
package prodacc_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  localparam int PROD_W = 16;
  localparam int BYTE_W = 8;

  // Largest positive two's-complement value of a w-bit word, zero-extended to 32 bits.
  function automatic logic [31:0] acc_max(input int w);
    return (32'h1 << (w - 1)) - 32'h1;
  endfunction

  // Most negative w-bit value; only the low w bits are meaningful.
  function automatic logic [31:0] acc_min(input int w);
    return ~acc_max(w);
  endfunction

endpackage

// File: rtl/product_accumulator_acc_sat_add.sv
// Combinational signed ACC_W adder with overflow flag.
// PRODUCT_ACCUMULATOR_SATURATE_EN clamps overflowing sums instead of wrapping.
module acc_sat_add
  import prodacc_pkg::*;
#(
  parameter int ACC_W = 24
) (
  input  logic [ACC_W-1:0] a,
  input  logic [ACC_W-1:0] b,
  output logic [ACC_W-1:0] sum,
  output logic             ovf
);

  logic [ACC_W-1:0] raw;

  assign raw = a + b;
  assign ovf = (a[ACC_W-1] == b[ACC_W-1]) && (raw[ACC_W-1] != a[ACC_W-1]);

`ifdef PRODUCT_ACCUMULATOR_SATURATE_EN
  localparam logic [31:0] MAX_V = acc_max(ACC_W);
  localparam logic [31:0] MIN_V = acc_min(ACC_W);

  // On overflow both operands share a sign, so a's sign picks the rail.
  always_comb begin
    sum = raw;
    if (ovf) begin
      sum = a[ACC_W-1] ? MIN_V[ACC_W-1:0] : MAX_V[ACC_W-1:0];
    end
  end
`else
  assign sum = raw;
`endif

endmodule

// File: rtl/product_accumulator.sv
// Rebuilds signed 16-bit products from byte pairs and sums TERMS of them per result.
// Build option PRODUCT_ACCUMULATOR_SATURATE_EN selects saturating accumulation.
module product_accumulator
  import prodacc_pkg::*;
#(
  parameter int ACC_W = 24,
  parameter int TERMS = 8
) (
  input  logic                     clock,
  input  logic                     aclr,
  input  logic                     clear,
  input  logic [BYTE_W-1:0]        prod_hi,
  input  logic [BYTE_W-1:0]        prod_lo,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [ACC_W-1:0]         acc_out,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     overflow,
  output logic [$clog2(TERMS)-1:0] term_count
);

  localparam int CNT_W = $clog2(TERMS);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TERMS - 1);

  state_t           state;
  state_t           state_nx;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] prod_ext;
  logic [ACC_W-1:0] sum;
  logic             ovf;
  logic             sticky;
  logic             accept;
  logic             last;
  logic [PROD_W-1:0] prod;

  assign prod     = {prod_hi, prod_lo};
  assign prod_ext = {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod};

  acc_sat_add #(.ACC_W(ACC_W)) u_add (
    .a   (acc),
    .b   (prod_ext),
    .sum (sum),
    .ovf (ovf)
  );

  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      state <= ACCUM;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    in_ready = 1'b0;
    accept   = 1'b0;
    last     = 1'b0;
    case (state)
      ACCUM: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept = 1'b1;
          if (term_count == LAST_CNT) begin
            last     = 1'b1;
            state_nx = HOLD;
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_nx = ACCUM;
        end
      end
      default: state_nx = ACCUM;
    endcase
    // Abort wins over both handshakes.
    if (clear) begin
      state_nx = ACCUM;
      accept   = 1'b0;
      last     = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      acc        <= '0;
      term_count <= '0;
      sticky     <= 1'b0;
      acc_out    <= '0;
      out_valid  <= 1'b0;
      overflow   <= 1'b0;
    end else if (clear) begin
      acc        <= '0;
      term_count <= '0;
      sticky     <= 1'b0;
      out_valid  <= 1'b0;
    end else begin
      if (accept && last) begin
        acc_out    <= sum;
        overflow   <= sticky | ovf;
        out_valid  <= 1'b1;
        acc        <= '0;
        term_count <= '0;
        sticky     <= 1'b0;
      end else if (accept) begin
        acc        <= sum;
        term_count <= term_count + CNT_W'(1);
        sticky     <= sticky | ovf;
      end
      if (state == HOLD && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_product_accumulator.sv
// Scoreboard bench for product_accumulator: a 24-bit and a 17-bit instance, TERMS=4.
// Expected results for the 17-bit overflow case follow PRODUCT_ACCUMULATOR_SATURATE_EN.
module tb_product_accumulator;

  typedef struct {
    int acc;
    bit ovf;
  } exp_t;

  logic clock = 1'b0;
  logic aclr  = 1'b1;

  logic        a_clear = 0, a_in_valid = 0, a_out_ready = 0;
  logic [7:0]  a_hi = 0, a_lo = 0;
  logic        a_in_ready, a_out_valid, a_overflow;
  logic [23:0] a_acc_out;
  logic [1:0]  a_term_count;

  logic        b_clear = 0, b_in_valid = 0, b_out_ready = 0;
  logic [7:0]  b_hi = 0, b_lo = 0;
  logic        b_in_ready, b_out_valid, b_overflow;
  logic [16:0] b_acc_out;
  logic [1:0]  b_term_count;

  exp_t qa[$];
  exp_t qb[$];
  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  product_accumulator #(.ACC_W(24), .TERMS(4)) dut_a (
    .clock(clock), .aclr(aclr), .clear(a_clear),
    .prod_hi(a_hi), .prod_lo(a_lo), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .acc_out(a_acc_out), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .overflow(a_overflow), .term_count(a_term_count)
  );

  product_accumulator #(.ACC_W(17), .TERMS(4)) dut_b (
    .clock(clock), .aclr(aclr), .clear(b_clear),
    .prod_hi(b_hi), .prod_lo(b_lo), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .acc_out(b_acc_out), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .overflow(b_overflow), .term_count(b_term_count)
  );

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Pops an expected result whenever a DUT hands one over.
  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clock);
      if (a_out_valid && a_out_ready) begin
        if (qa.size() == 0) begin
          chk("a_unexpected_result", 1, 0);
        end else begin
          e = qa.pop_front();
          chk("a_acc_out", int'($signed(a_acc_out)), e.acc);
          chk("a_overflow", int'(a_overflow), int'(e.ovf));
        end
      end
      if (b_out_valid && b_out_ready) begin
        if (qb.size() == 0) begin
          chk("b_unexpected_result", 1, 0);
        end else begin
          e = qb.pop_front();
          chk("b_acc_out", int'($signed(b_acc_out)), e.acc);
          chk("b_overflow", int'(b_overflow), int'(e.ovf));
        end
      end
    end
  endtask

  task automatic drive_a(input logic [7:0] hi, input logic [7:0] lo);
    a_hi = hi;
    a_lo = lo;
    a_in_valid = 1'b1;
    @(posedge clock);
    #1;
  endtask

  task automatic drive_b(input logic [7:0] hi, input logic [7:0] lo);
    b_hi = hi;
    b_lo = lo;
    b_in_valid = 1'b1;
    @(posedge clock);
    #1;
  endtask

  initial begin
    fork
      monitor();
    join_none

    repeat (2) @(posedge clock);
    #1 aclr = 1'b0;

    // Reset state
    @(negedge clock);
    chk("rst_out_valid", int'(a_out_valid), 0);
    chk("rst_in_ready", int'(a_in_ready), 1);
    chk("rst_acc_out", int'(a_acc_out), 0);
    chk("rst_term_count", int'(a_term_count), 0);
    chk("rst_overflow", int'(a_overflow), 0);

    // Four 258 terms back-to-back, consumer ready
    @(posedge clock);
    #1;
    a_out_ready = 1'b1;
    qa.push_back('{acc: 1032, ovf: 1'b0});
    for (int i = 0; i < 4; i++) begin
      chk("acc_in_ready", int'(a_in_ready), 1);
      drive_a(8'h01, 8'h02);
    end
    a_in_valid = 1'b0;
    @(negedge clock);
    chk("latency_out_valid", int'(a_out_valid), 1);
    chk("hold_in_ready", int'(a_in_ready), 0);
    chk("done_term_count", int'(a_term_count), 0);
    @(posedge clock);
    #1;
    @(negedge clock);
    chk("back_in_ready", int'(a_in_ready), 1);
    chk("back_out_valid", int'(a_out_valid), 0);

    // Negative sum held while consumer stalls
    @(posedge clock);
    #1;
    a_out_ready = 1'b0;
    qa.push_back('{acc: -500, ovf: 1'b0});
    for (int i = 0; i < 3; i++) drive_a(8'hFF, 8'h38);
    drive_a(8'h00, 8'h64);
    a_in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      chk("stall_in_ready", int'(a_in_ready), 0);
      chk("stall_out_valid", int'(a_out_valid), 1);
      chk("stall_acc_out", int'($signed(a_acc_out)), -500);
    end
    @(posedge clock);
    #1;
    a_out_ready = 1'b1;
    @(posedge clock);
    #1;
    @(negedge clock);
    chk("release_in_ready", int'(a_in_ready), 1);

    // clear mid-frame blocks a simultaneous term
    @(posedge clock);
    #1;
    drive_a(8'h01, 8'h02);
    drive_a(8'h01, 8'h02);
    a_in_valid = 1'b0;
    @(negedge clock);
    chk("partial_term_count", int'(a_term_count), 2);
    @(posedge clock);
    #1;
    a_clear = 1'b1;
    drive_a(8'h01, 8'h02);
    a_clear = 1'b0;
    a_in_valid = 1'b0;
    @(negedge clock);
    chk("clear_term_count", int'(a_term_count), 0);
    chk("clear_out_valid", int'(a_out_valid), 0);
    @(posedge clock);
    #1;
    qa.push_back('{acc: 1032, ovf: 1'b0});
    for (int i = 0; i < 4; i++) drive_a(8'h01, 8'h02);
    a_in_valid = 1'b0;
    repeat (3) @(posedge clock);
    #1;

    // 17-bit accumulator: four -32768 terms
    b_out_ready = 1'b1;
`ifdef PRODUCT_ACCUMULATOR_SATURATE_EN
    qb.push_back('{acc: -65536, ovf: 1'b1});
`else
    qb.push_back('{acc: 0, ovf: 1'b1});
`endif
    for (int i = 0; i < 4; i++) drive_b(8'h80, 8'h00);
    b_in_valid = 1'b0;
    repeat (3) @(posedge clock);
    #1;

    // aclr while holding a result
    a_out_ready = 1'b0;
    for (int i = 0; i < 4; i++) drive_a(8'h01, 8'h02);
    a_in_valid = 1'b0;
    @(negedge clock);
    chk("prereset_out_valid", int'(a_out_valid), 1);
    #1 aclr = 1'b1;
    #1;
    chk("aclr_out_valid", int'(a_out_valid), 0);
    chk("aclr_acc_out", int'(a_acc_out), 0);
    @(posedge clock);
    #1 aclr = 1'b0;
    @(negedge clock);
    chk("post_aclr_in_ready", int'(a_in_ready), 1);
    chk("post_aclr_term_count", int'(a_term_count), 0);
    chk("post_aclr_out_valid", int'(a_out_valid), 0);

    repeat (3) @(posedge clock);
    chk("a_results_pending", qa.size(), 0);
    chk("b_results_pending", qb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
